// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter granting one SPI transaction at a time to NREQ requesters
// Optional WAIT watchdog enabled by defining SPI_ARB_WATCHDOG_EN.
module spi_txn_arbiter #(
   parameter int  NREQ           = 4,
   parameter int  DW             = 16,
   parameter int  GAP_CYCLES     = 4,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int GW             = $clog2(NREQ)
) (
   input  logic               S_AXI_ACLK,
   input  logic               S_AXI_ARESETN,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               rsp_err,
   output logic               eng_start,
   output logic [DW-1:0]      eng_txdata,
   input  logic               eng_busy,
   input  logic               eng_done,
   input  logic [DW-1:0]      eng_rxdata,
   output logic [NREQ-1:0]    cs_n,
   output logic [GW-1:0]      grant_id
);

   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

   state_t            state;
   logic [GCW-1:0]    gap_cnt;
   logic [GW-1:0]     winner;
   logic [NREQ-1:0]   win_oh;
   logic [NREQ-1:0]   own_oh;
   logic              gap_last;
   logic              arb_now;

   // Nearest requester above the last owner wins; the last owner itself ranks lowest.
   always_comb begin
      int idx;
      idx    = 0;
      winner = grant_id;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(grant_id) + k) % NREQ;
         if (req_valid[idx]) winner = GW'(idx);
      end
   end

   assign win_oh   = NREQ'(1) << winner;
   assign own_oh   = NREQ'(1) << grant_id;
   assign gap_last = (state == GAP) && (gap_cnt == GCW'(GAP_CYCLES - 1));
   // The final GAP cycle doubles as the idle sampling point so a persistent requester sees no extra cycle.
   assign arb_now  = (|req_valid) && ((state == IDLE) || gap_last);

`ifdef SPI_ARB_WATCHDOG_EN
   localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WCW-1:0] wd_cnt;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
   assign rsp_err    = 1'b0;
`endif

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         req_ready  <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         eng_start  <= 1'b0;
         eng_txdata <= '0;
         cs_n       <= '1;
         grant_id   <= GW'(NREQ - 1);
`ifdef SPI_ARB_WATCHDOG_EN
         wd_cnt     <= '0;
         rsp_err    <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         eng_start <= 1'b0;
         if (arb_now) begin
            req_ready  <= win_oh;
            eng_txdata <= req_data[int'(winner)*DW +: DW];
            grant_id   <= winner;
            cs_n       <= ~win_oh;
            state      <= ISSUE;
         end else begin
            case (state)
               IDLE: ;
               ISSUE: begin
                  if (!eng_busy) begin
                     eng_start <= 1'b1;
                     state     <= WAIT;
`ifdef SPI_ARB_WATCHDOG_EN
                     wd_cnt    <= '0;
`endif
                  end
               end
               WAIT: begin
                  if (eng_done) begin
                     rsp_data  <= eng_rxdata;
                     rsp_valid <= own_oh;
                     cs_n      <= '1;
                     state     <= RESP;
`ifdef SPI_ARB_WATCHDOG_EN
                     rsp_err   <= 1'b0;
                  end else if (wd_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= own_oh;
                     cs_n      <= '1;
                     state     <= RESP;
                  end else begin
                     wd_cnt    <= wd_cnt + 1'b1;
`endif
                  end
               end
               RESP: begin
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end
               GAP: begin
                  if (gap_last) state <= IDLE;
                  else gap_cnt <= gap_cnt + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
